// File: rtl/tone_sequencer.sv
// tone_sequencer
//   Plays a fixed melody from an internal constant ROM onto a passive buzzer.
//   Each ROM entry is 8 bits: [7:4] pitch code (1..7 = C4..B4, 8..14 = C5..B5,
//   0/15 = rest), [3:0] duration in BEAT_DIV-cycle units (0 is treated as 1).
//
//   Parameters:
//     CLK_HZ   system clock frequency in Hz
//     BEAT_DIV clk cycles per duration unit
//     SONG_LEN number of melody entries (1..32)
//     SONG_ROM melody contents, entry i at bits [8*i +: 8]
//
//   Ports:
//     clk       system clock, rising edge
//     rst_n     asynchronous active-low reset
//     play      run/pause level, asynchronous (synchronized here)
//     restart   synchronous one-cycle pulse back to IDLE at entry 0
//     buzzer    square-wave output
//     note_idx  current melody entry
//     busy      high in PLAY and PAUSE
//     done      high in DONE
//
//   Build option: define TONE_LOOP_EN to wrap from the last entry back to
//   entry 0 instead of stopping in DONE (done is then constant 0).
module tone_sequencer #(
  parameter int           CLK_HZ   = 50_000_000,
  parameter int           BEAT_DIV = 6_250_000,
  parameter int           SONG_LEN = 32,
  parameter logic [255:0] SONG_ROM =
    256'h0F00_C2B2_A292_8272_6252_4232_1204_C4B4_A494_8474_6454_4434_1442_3242_5262_5161
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       restart,
  output logic       buzzer,
  output logic [4:0] note_idx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

  localparam logic [4:0] LAST_IDX = 5'(SONG_LEN - 1);
`ifdef TONE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  state_t      r_state, w_nxt;
  logic        r_sync1, r_sync2;
  logic [19:0] r_tone;
  logic [31:0] r_beat;
  logic [4:0]  r_idx;
  logic        r_buz, r_busy, r_done;

  logic        w_play_s;
  logic [7:0]  w_entry;
  logic [3:0]  w_dur;
  logic [19:0] w_half;
  logic [31:0] w_len;
  logic        w_note_end, w_last;

  // Half-period in clk cycles for each pitch code; 0 marks a rest.
  function automatic logic [19:0] half_of(input logic [3:0] p);
    case (p)
      4'd1:    half_of = 20'(CLK_HZ / (2 * 262));
      4'd2:    half_of = 20'(CLK_HZ / (2 * 294));
      4'd3:    half_of = 20'(CLK_HZ / (2 * 330));
      4'd4:    half_of = 20'(CLK_HZ / (2 * 349));
      4'd5:    half_of = 20'(CLK_HZ / (2 * 392));
      4'd6:    half_of = 20'(CLK_HZ / (2 * 440));
      4'd7:    half_of = 20'(CLK_HZ / (2 * 494));
      4'd8:    half_of = 20'(CLK_HZ / (2 * 523));
      4'd9:    half_of = 20'(CLK_HZ / (2 * 587));
      4'd10:   half_of = 20'(CLK_HZ / (2 * 659));
      4'd11:   half_of = 20'(CLK_HZ / (2 * 698));
      4'd12:   half_of = 20'(CLK_HZ / (2 * 784));
      4'd13:   half_of = 20'(CLK_HZ / (2 * 880));
      4'd14:   half_of = 20'(CLK_HZ / (2 * 988));
      default: half_of = 20'd0;
    endcase
  endfunction

  assign w_play_s   = r_sync2;
  assign w_entry    = SONG_ROM[{r_idx, 3'b000} +: 8];
  assign w_dur      = (w_entry[3:0] == 4'd0) ? 4'd1 : w_entry[3:0];
  assign w_half     = half_of(w_entry[7:4]);
  assign w_len      = 32'(w_dur) * 32'(BEAT_DIV);
  assign w_note_end = (r_state == S_PLAY) && (r_beat == w_len - 32'd1);
  assign w_last     = (r_idx == LAST_IDX);

  always_comb begin
    w_nxt = r_state;
    if (restart) w_nxt = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:  if (w_play_s) w_nxt = S_PLAY;
        // A finishing last note takes precedence over pausing; otherwise a
        // note end still completes and the pause lands on the new index.
        S_PLAY:  if (w_note_end && w_last && !LOOP) w_nxt = S_DONE;
                 else if (!w_play_s)                w_nxt = S_PAUSE;
        S_PAUSE: if (w_play_s) w_nxt = S_PLAY;
        default: w_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= S_IDLE;
      r_tone  <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_buz   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= play;
      r_sync2 <= r_sync1;
      r_state <= w_nxt;
      r_busy  <= (w_nxt == S_PLAY) || (w_nxt == S_PAUSE);
      r_done  <= (w_nxt == S_DONE) && !LOOP;
      if (restart) begin
        r_tone <= '0;
        r_beat <= '0;
        r_idx  <= '0;
        r_buz  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_tone <= '0;
            r_beat <= '0;
            r_idx  <= '0;
            r_buz  <= 1'b0;
          end
          S_PLAY: begin
            if (w_note_end) begin
              r_tone <= '0;
              r_beat <= '0;
              r_buz  <= 1'b0;
              if (!w_last)  r_idx <= r_idx + 5'd1;
              else if (LOOP) r_idx <= '0;
            end else begin
              r_beat <= r_beat + 32'd1;
              if (w_half == 20'd0) begin
                r_tone <= '0;
                r_buz  <= 1'b0;
              end else if (r_tone == w_half - 20'd1) begin
                r_tone <= '0;
                r_buz  <= ~r_buz;
              end else begin
                r_tone <= r_tone + 20'd1;
              end
              // Counting stops from the next cycle on; silence the buzzer now.
              if (!w_play_s) r_buz <= 1'b0;
            end
          end
          S_PAUSE: begin
            r_buz <= 1'b0;
            if (w_play_s) r_tone <= '0;  // tone phase restarts on resume
          end
          default: r_buz <= 1'b0;
        endcase
      end
    end
  end

  assign buzzer   = r_buz;
  assign note_idx = r_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;
  localparam int CLK_HZ   = 20_000;
  localparam int BEAT_DIV = 40;
  localparam int SONG_LEN = 6;
`ifdef TONE_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       play = 1'b0;
  logic       restart = 1'b0;
  logic       buzzer;
  logic [4:0] note_idx;
  logic       busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // Melody under test: A4 x1, rest x3, B5 x2, C4 dur0(->1), rest x1, C5 x2
  logic [7:0] song [SONG_LEN] = '{8'h61, 8'h03, 8'hE2, 8'h10, 8'hF1, 8'h82};
  int freq [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                    523, 587, 659, 698, 784, 880, 988, 0};

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .BEAT_DIV(BEAT_DIV), .SONG_LEN(SONG_LEN),
    .SONG_ROM(256'h82F1_10E2_0361)
  ) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .restart(restart),
    .buzzer(buzzer), .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: state 0=idle 1=play 2=pause 3=done; k = cycles played in
  // current note, t = cycles since tone phase start.
  int m_state, m_idx, m_k, m_t, m_buz, m_s1, m_s2;

  function automatic int mlen(input int idx);
    int d = int'(song[idx][3:0]);
    if (d == 0) d = 1;
    return d * BEAT_DIV;
  endfunction

  function automatic int mhalf(input int idx);
    int f = freq[song[idx][7:4]];
    return (f == 0) ? 0 : CLK_HZ / (2 * f);
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_buz[0], 5'(m_idx), (m_state == 1 || m_state == 2), (m_state == 3)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_k = 0; m_t = 0; m_buz = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic model_step();
    int ps = m_s2;
    int len, h;
    m_s2 = m_s1;
    m_s1 = int'(play);
    if (restart) begin
      m_state = 0; m_idx = 0; m_k = 0; m_t = 0; m_buz = 0;
      return;
    end
    case (m_state)
      0: if (ps != 0) begin m_state = 1; m_k = 0; m_t = 0; end
      1: begin
        len = mlen(m_idx);
        h   = mhalf(m_idx);
        m_k++; m_t++;
        if (m_k == len) begin
          m_k = 0; m_t = 0; m_buz = 0;
          if (m_idx == SONG_LEN - 1) begin
            if (LOOP) m_idx = 0; else m_state = 3;
          end else m_idx++;
        end else m_buz = (h == 0) ? 0 : (m_t / h) % 2;
        if (ps == 0 && m_state == 1) begin m_state = 2; m_buz = 0; end
      end
      2: if (ps != 0) begin m_state = 1; m_t = 0; end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; play = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if ({buzzer, note_idx, busy, done} !== 8'h00) begin
      n_fail++; $display("FAIL reset_state got=%h exp=00", {buzzer, note_idx, busy, done});
    end
    rst_n = 1'b1;
    repeat (4) begin
      tick();
      n_tests++;
      if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
        n_fail++; $display("FAIL idle_hold got=%h exp=%h", {buzzer, note_idx, busy, done}, exp_vec());
      end
    end
  endtask

  task automatic test_full_song();
    int total = 0;
    int cnt = 0;
    bit seen_done = 0;
    bit wrapped = 0;
    for (int i = 0; i < SONG_LEN; i++) total += mlen(i);
    play = 1'b1;
    for (int c = 0; c < total + 60; c++) begin
      tick();
      cnt++;
      n_tests++;
      if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
        n_fail++; $display("FAIL song cyc=%0d got=%h exp=%h", cnt, {buzzer, note_idx, busy, done}, exp_vec());
      end
      if (cnt > 3 && note_idx == 5'd0) wrapped = 1;
      if (done === 1'b1 && !seen_done) begin
        seen_done = 1;
        n_tests++;
        if (cnt != 3 + total || buzzer !== 1'b0 || note_idx !== 5'(SONG_LEN - 1)) begin
          n_fail++; $display("FAIL done_timing got=%0d idx=%0d buz=%b exp=%0d idx=%0d buz=0",
                             cnt, note_idx, buzzer, 3 + total, SONG_LEN - 1);
        end
      end
    end
`ifdef TONE_LOOP_EN
    n_tests++;
    if (seen_done || !wrapped || busy !== 1'b1) begin
      n_fail++; $display("FAIL loop_wrap got done=%b wrapped=%b busy=%b exp done=0 wrapped=1 busy=1", seen_done, wrapped, busy);
    end
`else
    n_tests++;
    if (!seen_done) begin
      n_fail++; $display("FAIL done_timeout got=0 exp=1 within %0d cycles", total + 60);
    end
`endif
    pulse_restart();
    play = 1'b0;
    n_tests++;
    if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
      n_fail++; $display("FAIL restart_from_end got=%h exp=%h", {buzzer, note_idx, busy, done}, exp_vec());
    end
    repeat (4) tick();
  endtask

  task automatic test_pause_random();
    int hold = 0;
    play = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        play = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 25);
      end
      hold--;
      tick();
      n_tests++;
      if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
        n_fail++; $display("FAIL pause_rand cyc=%0d play=%b got=%h exp=%h", c, play, {buzzer, note_idx, busy, done}, exp_vec());
      end
    end
    play = 1'b0;
    pulse_restart();
    repeat (4) tick();
  endtask

  task automatic test_restart_note_end();
    for (int r = 0; r < 4; r++) begin
      int skip = $urandom_range(0, 3);
      bit found = 0;
      play = 1'b1;
      for (int c = 0; c < 1000; c++) begin
        tick();
        n_tests++;
        if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
          n_fail++; $display("FAIL pre_restart cyc=%0d got=%h exp=%h", c, {buzzer, note_idx, busy, done}, exp_vec());
        end
        if (m_state == 1 && m_k == mlen(m_idx) - 1) begin
          if (skip == 0) begin found = 1; break; end
          skip--;
        end
      end
      n_tests++;
      if (!found) begin
        n_fail++; $display("FAIL restart_seek got=timeout exp=note_end");
      end else begin
        pulse_restart();
        if (note_idx !== 5'd0 || busy !== 1'b0 || done !== 1'b0 || buzzer !== 1'b0) begin
          n_fail++; $display("FAIL restart_at_end got idx=%0d busy=%b done=%b exp idx=0 busy=0 done=0", note_idx, busy, done);
        end
      end
      play = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_async_reset();
    play = 1'b1;
    repeat ($urandom_range(60, 300)) tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({buzzer, note_idx, busy, done} !== 8'h00) begin
      n_fail++; $display("FAIL async_reset got=%h exp=00", {buzzer, note_idx, busy, done});
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 120; c++) begin
      tick();
      n_tests++;
      if ({buzzer, note_idx, busy, done} !== exp_vec()) begin
        n_fail++; $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, {buzzer, note_idx, busy, done}, exp_vec());
      end
    end
    play = 1'b0;
    pulse_restart();
  endtask

  initial begin
    test_reset();
    test_full_song();
    test_pause_random();
    test_restart_note_end();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
